// File: rtl/spike_pkg.sv
// Shared spike-interface definitions: window default, derived widths and the
// rate_out channel slice convention used by the neuron layer, encoder and decoder.
package spike_pkg;

  localparam int WINDOW_LOG2_DEF = 4;

  // One extra bit so a fully saturated window (2^wl spikes) does not wrap.
  function automatic int cnt_w(input int wl);
    return wl + 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Channel ch of a flat rate vector lives at [ch*cw +: cw].
  function automatic int ch_lsb(input int ch, input int cw);
    return ch * cw;
  endfunction

endpackage

// File: rtl/spike_argmax.sv
// Combinational argmax over N_CH packed counts; ties go to the lowest index,
// all-zero input reports index 0 with all_zero set.
module spike_argmax
  import spike_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int CNT_W = 5,
  parameter int IDX_W = 1
) (
  input  logic [N_CH*CNT_W-1:0] counts,
  output logic [IDX_W-1:0]      idx,
  output logic                  all_zero
);

  always_comb begin : scan_p
    logic [CNT_W-1:0] best;
    best     = counts[CNT_W-1:0];
    idx      = '0;
    all_zero = (counts == '0);
    // Strict greater-than keeps the earliest channel on a tie.
    for (int i = 1; i < N_CH; i++) begin
      if (counts[ch_lsb(i, CNT_W) +: CNT_W] > best) begin
        best = counts[ch_lsb(i, CNT_W) +: CNT_W];
        idx  = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Per-channel spike counting over a fixed enabled-cycle window, with a
// registered valid/ready result stage carrying rates, winner and no_spike.
module spike_rate_decoder
  import spike_pkg::*;
#(
  parameter int  N_CH        = 2,
  parameter int  WINDOW_LOG2 = WINDOW_LOG2_DEF,
  localparam int CNT_W       = cnt_w(WINDOW_LOG2),
  localparam int IDX_W       = idx_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_CH-1:0]       spike_in,
  output logic [N_CH*CNT_W-1:0] rate_out,
  output logic [IDX_W-1:0]      winner,
  output logic                  no_spike,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
);

  logic [WINDOW_LOG2-1:0]       win_cnt_q, win_cnt_d;
  logic [N_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d, lat;
  logic [N_CH-1:0][CNT_W-1:0]   rate_q, rate_d;
  logic [IDX_W-1:0]             winner_q, winner_d, am_idx;
  logic                         no_spike_q, no_spike_d, am_zero;
  logic                         valid_q, valid_d;
  logic                         overrun_q, overrun_d;
  logic                         we;

  // Running count including this cycle's spike, so the last window cycle counts.
  always_comb begin
    lat = '0;
    for (int i = 0; i < N_CH; i++) lat[i] = cnt_q[i] + CNT_W'(spike_in[i]);
  end

  assign we = en && (win_cnt_q == '1);

  spike_argmax #(
    .N_CH (N_CH),
    .CNT_W(CNT_W),
    .IDX_W(IDX_W)
  ) u_argmax (
    .counts  (lat),
    .idx     (am_idx),
    .all_zero(am_zero)
  );

  always_comb begin
    win_cnt_d  = win_cnt_q;
    cnt_d      = cnt_q;
    rate_d     = rate_q;
    winner_d   = winner_q;
    no_spike_d = no_spike_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    if (en) begin
      win_cnt_d = win_cnt_q + 1'b1;
      cnt_d     = we ? '0 : lat;
    end
    if (we) begin
      rate_d     = lat;
      winner_d   = am_idx;
      no_spike_d = am_zero;
      valid_d    = 1'b1;
      if (valid_q && !out_ready) overrun_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_q  <= '0;
      cnt_q      <= '0;
      rate_q     <= '0;
      winner_q   <= '0;
      no_spike_q <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      cnt_q      <= cnt_d;
      rate_q     <= rate_d;
      winner_q   <= winner_d;
      no_spike_q <= no_spike_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rate_out  = rate_q;
  assign winner    = winner_q;
  assign no_spike  = no_spike_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder (N_CH=2, 16-cycle window).
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst, en, out_ready;
  logic [1:0] spike_in;
  logic [9:0] rate_out;
  logic       winner, no_spike, out_valid, overrun;

  typedef struct packed {
    logic [9:0] rate;
    logic       win;
    logic       ns;
    logic       ov;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  spike_rate_decoder #(.N_CH(2), .WINDOW_LOG2(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .spike_in (spike_in),
    .rate_out (rate_out),
    .winner   (winner),
    .no_spike (no_spike),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input int c0, input int c1, input logic w,
                              input logic ns, input logic ov);
    exp_t e;
    e.rate = {5'(c1), 5'(c0)};
    e.win  = w;
    e.ns   = ns;
    e.ov   = ov;
    return e;
  endfunction

  // Monitor: every accepted transfer is checked against the next expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_xfer", 32'({rate_out, winner, no_spike, overrun}), 32'h1fff_ffff);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("xfer", 32'({rate_out, winner, no_spike, overrun}), 32'(e));
      end
    end
  end

  task automatic step(input logic e, input logic [1:0] s);
    en       = e;
    spike_in = s;
    @(posedge clk);
    #1;
  endtask

  // Channel c spikes at cycles k = 0, p, 2p, ... for n spikes total.
  task automatic run_win(input int n0, input int p0, input int n1, input int p1,
                         input bit chk_drop, input bit rdy_last);
    for (int k = 0; k < 16; k++) begin
      logic s0, s1;
      s0 = (n0 > 0) && (k % p0 == 0) && (k < n0 * p0);
      s1 = (n1 > 0) && (k % p1 == 0) && (k < n1 * p1);
      if (rdy_last) out_ready = (k == 15);
      step(1'b1, {s1, s0});
      if (k == 0 && chk_drop) chk("valid_one_cycle", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; out_ready = 1'b0; spike_in = 2'b00;

    for (int k = 0; k < 3; k++) step(1'b1, (k % 2 == 0) ? 2'b11 : 2'b00);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 2'b11);
      chk("reset_idle", 32'({rate_out, winner, no_spike, out_valid, overrun}), 32'd0);
    end

    // Saturated ch0, silent ch1.
    out_ready = 1'b1;
    q.push_back(mk(16, 0, 1'b0, 1'b0, 1'b0));
    run_win(16, 1, 0, 1, 1'b0, 1'b0);
    chk("valid_rise", 32'(out_valid), 32'd1);

    q.push_back(mk(4, 8, 1'b1, 1'b0, 1'b0));
    run_win(4, 4, 8, 2, 1'b1, 1'b0);
    q.push_back(mk(5, 5, 1'b0, 1'b0, 1'b0));
    run_win(5, 3, 5, 3, 1'b0, 1'b0);
    q.push_back(mk(0, 0, 1'b0, 1'b1, 1'b0));
    run_win(0, 1, 0, 1, 1'b0, 1'b0);
    step(1'b0, 2'b00);

    // Backpressure: first window is overwritten and never transferred.
    out_ready = 1'b0;
    run_win(3, 2, 7, 2, 1'b0, 1'b0);
    q.push_back(mk(6, 2, 1'b0, 1'b0, 1'b1));
    run_win(6, 2, 2, 3, 1'b0, 1'b0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_overrun", 32'(overrun), 32'd1);
    chk("bp_rate", 32'(rate_out), 32'({5'd2, 5'd6}));
    q.push_back(mk(1, 9, 1'b1, 1'b0, 1'b1));
    run_win(1, 1, 9, 1, 1'b0, 1'b1);
    chk("bp_we_valid", 32'(out_valid), 32'd1);
    chk("bp_we_overrun", 32'(overrun), 32'd1);

    // Enable gating: 5 disabled cycles stretch the window to 21.
    q.push_back(mk(16, 0, 1'b0, 1'b0, 1'b1));
    for (int t = 0; t < 21; t++) begin
      step(!(t >= 8 && t < 13), 2'b01);
      if (t == 19) chk("gate_early", 32'(out_valid), 32'd0);
    end
    chk("gate_valid", 32'(out_valid), 32'd1);
    chk("gate_rate", 32'(rate_out), 32'({5'd0, 5'd16}));

    // Mid-window reset discards partial counts and overrun.
    for (int k = 0; k < 8; k++) step(1'b1, 2'b11);
    rst = 1'b1;
    step(1'b1, 2'b11);
    rst = 1'b0;
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    q.push_back(mk(2, 3, 1'b1, 1'b0, 1'b0));
    run_win(2, 1, 3, 4, 1'b0, 1'b0);

    for (int k = 0; k < 40 && q.size() != 0; k++) step(1'b0, 2'b00);
    chk("drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Receiving end of the spike interface driven by the LIF neuron layer. Counts incoming spikes per channel over a fixed window of enabled cycles and publishes the per-channel rate codes. It also publishes the winning (most-active) channel. Results are handed to downstream logic through a valid/ready output stage. The block sits directly after the neuron spike outputs and turns spike trains back into binary values for readout and classification.

## Interface
Parameters:
- `N_CH`, 2, number of spike channels.
- `WINDOW_LOG2`, 4, window length is 2^WINDOW_LOG2 enabled cycles (16 by default).

Derived values:
- `CNT_W` = WINDOW_LOG2+1, enough to hold a count of 2^WINDOW_LOG2 without saturation.
- `IDX_W` = max(1, clog2(N_CH)).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  counting enable; low freezes the window.
- `spike_in`  in  N_CH  one spike bit per channel, sampled each cycle.
- `rate_out`  out  N_CH*CNT_W  latched counts; channel i is at [i*CNT_W +: CNT_W].
- `winner`  out  IDX_W  index of the channel with the highest latched count.
- `no_spike`  out  1  all latched counts are zero.
- `out_valid`  out  1  a result is held.
- `out_ready`  in  1  consumer accepts the result.
- `overrun`  out  1  sticky; an unconsumed result was overwritten.

## Operation
- `win_cnt` (WINDOW_LOG2 bits) increments on each cycle with en=1 and wraps at 2^WINDOW_LOG2-1 to 0.
- Per-channel counter `cnt[i]` (CNT_W bits) adds spike_in[i] on each cycle with en=1.
- en=0: win_cnt and all counters hold; spike_in is ignored. The output handshake still operates.
- Window end (WE) is a cycle with en=1 and win_cnt = 2^WINDOW_LOG2-1. At WE:
  - the latched counts are cnt[i]+spike_in[i], so the final-cycle spike is included;
  - all cnt[i] clear to 0;
  - rate_out, winner and no_spike load from the latched counts;
  - out_valid is set.
- winner is the argmax of the latched counts. Ties resolve to the lowest index. All-zero counts give winner=0 and no_spike=1.
- Handshake: a transfer occurs when out_valid && out_ready. A transfer with no WE in the same cycle clears out_valid; rate_out, winner and no_spike hold their stale values.
- WE with out_valid=1 and out_ready=1: the old result is transferred, the new result loads, out_valid stays 1, overrun is unchanged.
- WE with out_valid=1 and out_ready=0: the new result overwrites the old one, out_valid stays 1, and overrun is set. overrun clears only on rst.
- rst at any point, including mid-window, discards all partial counts.

## Timing
- Reset values: rate_out=0, winner=0, no_spike=0, out_valid=0, overrun=0, win_cnt=0, cnt=0.
- Latency: outputs update and out_valid rises on the clock edge that ends the WE cycle, so they are visible one cycle after WE.
- Window period is exactly 2^WINDOW_LOG2 cycles with en=1; each en=0 cycle stretches it by one.
- First WE after reset is the 2^WINDOW_LOG2-th enabled cycle.
- All outputs are registered. No combinational path exists from spike_in or out_ready to any output.

## Structure
- Shared package `spike_pkg`:
  - default `WINDOW_LOG2`;
  - `CNT_W` and `IDX_W` helper functions;
  - the rate_out channel slice convention, shared with the neuron layer and the encoder.
- Sub-module `spike_argmax`: combinational comparator tree over N_CH counts with lowest-index tie-break. It outputs the index and the all-zero flag and is reusable by the classifier readout.
- Counters, window FSM and the output register stage live in `spike_rate_decoder`.

## Test plan
- Reset: hold rst 3 cycles with spikes toggling, then release with en=0 for 20 cycles -> every output stays 0 and out_valid never rises.
- Saturated window: N_CH=2, en=1, ch0 spikes every cycle, ch1 silent, out_ready=1 -> one cycle after the 16th cycle: rate ch0=16, ch1=0, winner=0, no_spike=0, out_valid=1 for exactly 1 cycle.
- Rates and ties:
  - ch1 every 2nd cycle, ch0 every 4th -> ch0=4, ch1=8, winner=1.
  - Next window, 5 spikes each -> winner=0.
  - Next window, silent -> no_spike=1, winner=0.
- Backpressure: out_ready=0 across two WEs -> out_valid=1, rate_out shows the second window, overrun=1. Then out_ready=1 coinciding with the next WE -> out_valid stays 1 and overrun stays 1; only rst clears it.
- Enable gating: drop en for 5 cycles mid-window with ch0 spiking every cycle -> WE occurs 21 cycles after window start and ch0=16.
- Mid-window reset: rst at cycle 8 of a window -> the next result reflects only spikes received after reset.
